vjtag_regfile_bridge: RTL and testbench
=======================================

Name: vjtag_regfile_bridge

Overview:
- Parametrised successor to the fixed eight-register virtual-JTAG adapter.
- Exposes NUM_REGS registers of REG_W bits each, selected by the virtual IR. Each register is either read-only (captured from core inputs) or read/write (driven to core outputs).
- All JTAG-side signals (tck, tdi, ir, TAP state flags) are oversampled and synchronised into the core clock, so every register and every strobe lives in the core clock domain.
- Sits between the sld_virtual_jtag instance and the CICERO control/status logic.

Parameters:
- NUM_REGS, 8, number of addressable registers; IR value k (1..NUM_REGS) selects register k-1; must satisfy NUM_REGS < 2**IR_W - 1.
- REG_W, 64, width of every register and of the shift register.
- IR_W, 4, virtual IR width.
- RO_MASK, 8'b1100_0001, bit k=1 makes register k read-only; width NUM_REGS.
- SYNC_STAGES, 2, synchroniser depth for JTAG inputs (>=2).
- ID_VALUE, 32'h0012_3456, identification constant (see optional feature).

Ports:
- clk  in  1  core clock; must be >= 2*(SYNC_STAGES+3) x f_tck.
- rst_n  in  1  asynchronous, active-low reset.
- jtag_tck  in  1  virtual JTAG TCK (sampled as data, never used as a clock).
- jtag_tdi  in  1  TDI.
- jtag_ir_in  in  IR_W  current virtual IR.
- jtag_cdr / jtag_sdr / jtag_udr  in  1 each  capture-DR, shift-DR and update-DR state flags.
- jtag_tdo  out  1  TDO.
- rd_data  in  NUM_REGS*REG_W  values captured for read-only registers; slice k is [k*REG_W +: REG_W].
- wr_data  out  NUM_REGS*REG_W  read/write register contents.
- wr_strobe  out  NUM_REGS  one-clk pulse when wr_data slice k updates.
- rd_strobe  out  NUM_REGS  one-clk pulse when read-only slice k is captured; lets producers pop a FIFO.
- len_err_cnt  out  8  saturating count of rejected updates.

Behaviour:
- Reset: wr_data=0, wr_strobe=0, rd_strobe=0, jtag_tdo=0, len_err_cnt=0, shift register=0, bit counter=0, FSM=IDLE, all synchroniser flops=0.
- Synchronisation:
  - tck, tdi, ir_in, cdr, sdr and udr all pass through SYNC_STAGES flops.
  - A tck rising event is synced tck=1 while its one-cycle-delayed copy=0.
  - On that event, use the delayed copies of tdi, ir and the state flags, i.e. the values present while tck was low.
- Flag priority: if more than one flag is set on an event (illegal), priority is cdr > sdr > udr.
- Selection:
  - sel = ir-1 when 1 <= ir <= NUM_REGS.
  - Otherwise the bypass path: a 1-bit register loads tdi on sdr; tdo=bypass bit.
- FSM states: IDLE, CAPTURED, SHIFTING. Transitions are evaluated only on tck rising events.
  - cdr, any state -> CAPTURED:
    - shift register = rd_data slice (read-only reg, plus rd_strobe[sel] pulse), or wr_data slice (read/write reg; readback of written value).
    - Bit counter cleared.
  - sdr, CAPTURED or SHIFTING -> SHIFTING:
    - Shift right; tdi enters the MSB.
    - Bit counter increments, saturating at REG_W+1.
  - sdr in IDLE: shift occurs, FSM stays IDLE, counter stays 0.
  - udr -> IDLE:
    - Read/write reg with counter==REG_W: wr_data slice = shift register; wr_strobe[sel] pulses one clk.
    - Read/write reg with counter!=REG_W: update discarded; len_err_cnt increments, saturating at 255.
    - Read-only reg: udr ignored.
- tdo: registered, equal to shift register bit 0 (or the bypass bit). It updates exactly 1 clk after the event clk.
- ir change mid-shift: no special handling; the next cdr recaptures.
- Strobes: never more than one wr_strobe or rd_strobe bit high in any cycle.
- Reset mid-scan: everything returns to reset values; partial shift data is lost.

Optional Feature:
- Macro: VJTAG_ID_REG_EN.
- Defined: IR = all-ones selects a read-only ID register. cdr loads ID_VALUE, zero-extended to REG_W; sdr shifts; udr is ignored.
- Undefined: IR = all-ones is bypass.

Decomposition:
- Package vjtag_bridge_pkg:
  - FSM state enum {IDLE, CAPTURED, SHIFTING}.
  - IR_BYPASS=0 and IR_ID=all-ones constants.
  - Function slice_index(k, REG_W).
- Sub-module vjtag_sync: SYNC_STAGES synchroniser plus the delay stage and tck rising-event detector. Outputs tck_rise_evt and the aligned tdi/ir/flags.

Test Plan:
- Write, then readback:
  - ir=2 (register 1, read/write); scan 64 bits 0xDEADBEEF_CAFEF00D with cdr, 64 sdr, udr -> wr_data[127:64]=0xDEADBEEF_CAFEF00D, wr_strobe=8'h02 for exactly 1 clk.
  - Rescan same register -> tdo stream LSB-first equals 0xDEADBEEF_CAFEF00D.
- Read-only capture: ir=1, rd_data[63:0]=0x0000_0000_0000_00A5; cdr, 64 sdr -> tdo bits 0xA5 LSB-first; rd_strobe=8'h01 pulse; wr_data unchanged.
- Length error: ir=3, shift 63 bits then udr -> wr_data slice 2 unchanged, no wr_strobe, len_err_cnt=1. Repeat 300 times -> len_err_cnt=255.
- Bypass: ir=0 and ir=9 (out of range, feature off); shift 1,0,1 -> tdo reproduces the pattern delayed by one tck; no strobes.
- ID register (VJTAG_ID_REG_EN defined): ir=4'hF, cdr, 32 sdr -> tdo yields 0x00123456. With the macro undefined, same stimulus -> bypass behaviour.
- Reset mid-scan: assert rst_n=0 after 20 sdr bits on ir=2 -> wr_data=0, FSM=IDLE, tdo=0. A full scan after release updates correctly.

Source files
------------

// File: rtl/vjtag_bridge_pkg.sv
// Shared types and helpers for the virtual-JTAG register-file bridge.
package vjtag_bridge_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURED, SHIFTING} state_t;

  localparam int          IR_BYPASS = 0;
  localparam logic [31:0] IR_ID     = '1;  // sliced to IR_W by the user

  function automatic int slice_index(input int k, input int reg_w);
    return k * reg_w;
  endfunction

endpackage

// File: rtl/vjtag_sync.sv
// Synchronises all JTAG-side inputs into clk, adds one delay stage and
// flags a tck rising event; data outputs are the delayed (tck-low) copies.
module vjtag_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int IR_W        = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tck,
  input  logic            tdi,
  input  logic [IR_W-1:0] ir_in,
  input  logic            cdr,
  input  logic            sdr,
  input  logic            udr,
  output logic            tck_rise_evt,
  output logic            tdi_d,
  output logic [IR_W-1:0] ir_d,
  output logic            cdr_d,
  output logic            sdr_d,
  output logic            udr_d
);

  localparam int W = IR_W + 5;

  logic [W-1:0] stage_q [SYNC_STAGES];
  logic [W-1:0] dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      dly_q <= '0;
    end else begin
      stage_q[0] <= {tck, tdi, ir_in, cdr, sdr, udr};
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      dly_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign tck_rise_evt = stage_q[SYNC_STAGES-1][W-1] & ~dly_q[W-1];
  assign {tdi_d, ir_d, cdr_d, sdr_d, udr_d} = dly_q[W-2:0];

endmodule

// File: rtl/vjtag_regfile_bridge.sv
// Parametrised virtual-JTAG register-file bridge, fully in the clk domain.
// Optional ID register at IR all-ones when VJTAG_ID_REG_EN is defined.
module vjtag_regfile_bridge
  import vjtag_bridge_pkg::*;
#(
  parameter int                  NUM_REGS    = 8,
  parameter int                  REG_W       = 64,
  parameter int                  IR_W        = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK     = 8'b1100_0001,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [31:0]         ID_VALUE    = 32'h0012_3456
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      jtag_tck,
  input  logic                      jtag_tdi,
  input  logic [IR_W-1:0]           jtag_ir_in,
  input  logic                      jtag_cdr,
  input  logic                      jtag_sdr,
  input  logic                      jtag_udr,
  output logic                      jtag_tdo,
  input  logic [NUM_REGS*REG_W-1:0] rd_data,
  output logic [NUM_REGS*REG_W-1:0] wr_data,
  output logic [NUM_REGS-1:0]       wr_strobe,
  output logic [NUM_REGS-1:0]       rd_strobe,
  output logic [7:0]                len_err_cnt
);

  localparam int               SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int               CNT_W  = $clog2(REG_W + 2);
  localparam logic [CNT_W-1:0] CNT_OK = CNT_W'(REG_W);
  localparam logic [CNT_W-1:0] CNT_MX = CNT_W'(REG_W + 1);
  localparam logic [REG_W-1:0] ID_EXT = REG_W'(ID_VALUE);

  logic            evt, tdi_a, cdr_a, sdr_a, udr_a;
  logic [IR_W-1:0] ir_a;

  vjtag_sync #(.SYNC_STAGES(SYNC_STAGES), .IR_W(IR_W)) u_sync (
    .clk(clk), .rst_n(rst_n), .tck(jtag_tck), .tdi(jtag_tdi), .ir_in(jtag_ir_in),
    .cdr(jtag_cdr), .sdr(jtag_sdr), .udr(jtag_udr),
    .tck_rise_evt(evt), .tdi_d(tdi_a), .ir_d(ir_a),
    .cdr_d(cdr_a), .sdr_d(sdr_a), .udr_d(udr_a)
  );

  logic             reg_hit, id_hit;
  logic [SEL_W-1:0] sel;

  always_comb begin
    reg_hit = (ir_a != IR_W'(IR_BYPASS)) && (32'(ir_a) <= NUM_REGS);
    sel     = SEL_W'(ir_a - 1'b1);
`ifdef VJTAG_ID_REG_EN
    id_hit  = (ir_a == IR_ID[IR_W-1:0]);
`else
    id_hit  = 1'b0;
`endif
  end

  state_t state_q, state_d;
  logic   do_cap, do_shift, do_upd;

  // cdr > sdr > udr when several flags are (illegally) set together
  always_comb begin
    state_d  = state_q;
    do_cap   = 1'b0;
    do_shift = 1'b0;
    do_upd   = 1'b0;
    if (evt) begin
      if (cdr_a) begin
        state_d = CAPTURED;
        do_cap  = 1'b1;
      end else if (sdr_a) begin
        do_shift = 1'b1;
        if (state_q != IDLE) state_d = SHIFTING;
      end else if (udr_a) begin
        state_d = IDLE;
        do_upd  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  logic [REG_W-1:0] sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             byp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      byp_q       <= 1'b0;
      jtag_tdo    <= 1'b0;
      wr_data     <= '0;
      wr_strobe   <= '0;
      rd_strobe   <= '0;
      len_err_cnt <= '0;
    end else begin
      wr_strobe <= '0;
      rd_strobe <= '0;
      jtag_tdo  <= (reg_hit || id_hit) ? sr_q[0] : byp_q;

      if (do_cap) begin
        cnt_q <= '0;
        if (id_hit) begin
          sr_q <= ID_EXT;
        end else if (reg_hit) begin
          if (RO_MASK[sel]) begin
            sr_q           <= rd_data[slice_index(int'(sel), REG_W) +: REG_W];
            rd_strobe[sel] <= 1'b1;
          end else begin
            sr_q <= wr_data[slice_index(int'(sel), REG_W) +: REG_W];
          end
        end
      end

      if (do_shift) begin
        if (reg_hit || id_hit) sr_q  <= {tdi_a, sr_q[REG_W-1:1]};
        else                   byp_q <= tdi_a;
        if (state_q != IDLE && cnt_q != CNT_MX) cnt_q <= cnt_q + 1'b1;
      end

      // counter is cleared on update so a stray sdr in IDLE keeps it at 0
      if (do_upd) begin
        cnt_q <= '0;
        if (reg_hit && !RO_MASK[sel]) begin
          if (cnt_q == CNT_OK) begin
            wr_data[slice_index(int'(sel), REG_W) +: REG_W] <= sr_q;
            wr_strobe[sel] <= 1'b1;
          end else if (len_err_cnt != 8'hFF) begin
            len_err_cnt <= len_err_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vjtag_regfile_bridge.sv
// Self-checking bench for vjtag_regfile_bridge: scans driven at the flag
// level with a slow tck, tdo streams checked through an expected-value queue.
module tb_vjtag_regfile_bridge;

  localparam int NUM_REGS = 8;
  localparam int REG_W    = 64;
  localparam int IR_W     = 4;
  localparam int HP       = 6;  // clk cycles per tck half period

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      jtag_tck = 1'b0, jtag_tdi = 1'b0;
  logic [IR_W-1:0]           jtag_ir_in = '0;
  logic                      jtag_cdr = 1'b0, jtag_sdr = 1'b0, jtag_udr = 1'b0;
  logic                      jtag_tdo;
  logic [NUM_REGS*REG_W-1:0] rd_data = '0;
  logic [NUM_REGS*REG_W-1:0] wr_data;
  logic [NUM_REGS-1:0]       wr_strobe, rd_strobe;
  logic [7:0]                len_err_cnt;

  always #5 clk = ~clk;

  vjtag_regfile_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .jtag_tck(jtag_tck), .jtag_tdi(jtag_tdi), .jtag_ir_in(jtag_ir_in),
    .jtag_cdr(jtag_cdr), .jtag_sdr(jtag_sdr), .jtag_udr(jtag_udr),
    .jtag_tdo(jtag_tdo), .rd_data(rd_data), .wr_data(wr_data),
    .wr_strobe(wr_strobe), .rd_strobe(rd_strobe), .len_err_cnt(len_err_cnt)
  );

  int                        vectors = 0, miscompares = 0;
  logic [63:0]               exp_q[$];
  logic [NUM_REGS*REG_W-1:0] wr_model = '0;

  // strobe monitor
  bit         mon_clr = 1'b0;
  logic [7:0] wr_or = '0, rd_or = '0;
  int         wr_cyc = 0, rd_cyc = 0, multi = 0;

  always @(negedge clk) begin
    if (mon_clr) begin
      wr_or = '0; rd_or = '0; wr_cyc = 0; rd_cyc = 0;
    end else begin
      wr_or = wr_or | wr_strobe;
      rd_or = rd_or | rd_strobe;
      if (wr_strobe != '0) wr_cyc++;
      if (rd_strobe != '0) rd_cyc++;
    end
    if ($countones({wr_strobe, rd_strobe}) > 1) multi++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag);
    for (int k = 0; k < NUM_REGS; k++)
      chk($sformatf("%s[%0d]", tag, k), wr_data[k*REG_W +: REG_W], wr_model[k*REG_W +: REG_W]);
  endtask

  task automatic clr_mon();
    @(posedge clk) mon_clr = 1'b1;
    @(posedge clk) mon_clr = 1'b0;
  endtask

  task automatic tck_cyc(input logic t, input logic c, input logic s, input logic u);
    @(negedge clk);
    jtag_tdi = t; jtag_cdr = c; jtag_sdr = s; jtag_udr = u; jtag_tck = 1'b0;
    repeat (HP) @(negedge clk);
    jtag_tck = 1'b1;
    repeat (HP - 1) @(negedge clk);
  endtask

  task automatic scan(input logic [IR_W-1:0] ir, input logic [63:0] din, input int n,
                      input bit upd, output logic [63:0] dout);
    jtag_ir_in = ir;
    tck_cyc(1'b0, 1'b1, 1'b0, 1'b0);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      if (i < 64) dout[i] = jtag_tdo;
      tck_cyc((i < 64) ? din[i] : 1'b0, 1'b0, 1'b1, 1'b0);
    end
    if (upd) tck_cyc(1'b0, 1'b0, 1'b0, 1'b1);
    tck_cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic scan_chk(input string tag, input logic [IR_W-1:0] ir, input logic [63:0] din,
                          input int n, input bit upd, input logic [63:0] exp);
    logic [63:0] d, e;
    exp_q.push_back(exp);
    scan(ir, din, n, upd, d);
    e = exp_q.pop_front();
    chk(tag, d, e);
  endtask

  localparam logic [63:0] W1 = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] W2 = 64'h01234567_89ABCDEF;
  localparam logic [31:0] P  = 32'h0012_3456;

  initial begin
    logic [63:0] d, e;
    logic        bits [3];
    logic [IR_W-1:0] byp_irs [2];
    bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1;
    byp_irs[0] = 4'd0; byp_irs[1] = 4'd9;

    rd_data[0*REG_W +: REG_W] = 64'h0000_0000_0000_00A5;
    rd_data[6*REG_W +: REG_W] = 64'h1111_2222_3333_4444;
    repeat (3) @(negedge clk);
    chk_wr("rst_wr");
    chk("rst_tdo", jtag_tdo, 0);
    chk("rst_len", len_err_cnt, 0);
    chk("rst_stb", {wr_strobe, rd_strobe}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // write register 1, then read it back
    clr_mon();
    scan_chk("wr_cap", 4'd2, W1, 64, 1'b1, 64'h0);
    wr_model[1*REG_W +: REG_W] = W1;
    chk_wr("wr1");
    chk("wr1_stb", wr_or, 8'h02);
    chk("wr1_stb_len", wr_cyc, 1);
    chk("wr1_rd_stb", rd_or, 8'h00);
    clr_mon();
    scan_chk("readback", 4'd2, W1, 64, 1'b1, W1);
    chk_wr("readback_wr");

    // read-only capture; its update is ignored
    clr_mon();
    scan_chk("ro_tdo", 4'd1, 64'h0, 64, 1'b1, 64'hA5);
    chk("ro_rd_stb", rd_or, 8'h01);
    chk("ro_rd_stb_len", rd_cyc, 1);
    chk("ro_wr_stb", wr_or, 8'h00);
    chk("ro_len", len_err_cnt, 0);
    chk_wr("ro_wr");

    // length errors: 63 bits, 65 bits, then saturate
    clr_mon();
    scan_chk("len63_tdo", 4'd3, '1, 63, 1'b1, 64'h0);
    chk("len63_cnt", len_err_cnt, 1);
    scan_chk("len65_tdo", 4'd4, '1, 65, 1'b1, 64'h0);
    chk("len65_cnt", len_err_cnt, 2);
    for (int i = 0; i < 298; i++) scan(4'd3, 64'h1, 1, 1'b1, d);
    chk("len_sat", len_err_cnt, 255);
    chk("len_wr_stb", wr_or, 8'h00);
    chk_wr("len_wr");

    // bypass on IR 0 and out-of-range IR 9
    clr_mon();
    foreach (byp_irs[j]) begin
      jtag_ir_in = byp_irs[j];
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(64'(bits[i]));
        tck_cyc(bits[i], 1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        chk($sformatf("byp_ir%0d_b%0d", byp_irs[j], i), jtag_tdo, e);
      end
    end
    chk("byp_stb", {wr_or, rd_or}, 0);

`ifdef VJTAG_ID_REG_EN
    scan_chk("id_reg", 4'hF, 64'h0, 32, 1'b0, 64'(P));
`else
    scan_chk("id_byp", 4'hF, 64'(P), 32, 1'b0, 64'({P[30:0], 1'b1}));
`endif

    // reset in the middle of a scan
    jtag_ir_in = 4'd2;
    tck_cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tck_cyc(1'b1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    wr_model = '0;
    chk_wr("midrst_wr");
    chk("midrst_tdo", jtag_tdo, 0);
    chk("midrst_len", len_err_cnt, 0);
    jtag_tck = 1'b0; jtag_sdr = 1'b0; jtag_tdi = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clr_mon();
    scan_chk("post_rst_cap", 4'd2, W2, 64, 1'b1, 64'h0);
    wr_model[1*REG_W +: REG_W] = W2;
    chk_wr("post_rst_wr");
    chk("post_rst_stb", wr_or, 8'h02);
    chk("post_rst_stb_len", wr_cyc, 1);

    chk("onehot_stb", multi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
